pwm_servo_ctrl: RTL and testbench

Frame-synchronous command sequencer for the two-channel PWM generator that drives the steering servo (ch0) and the throttle ESC (ch1). It accepts pulse-width commands from the host over a valid/ready interface, clamps them, and slew-limits them. It runs an ESC arming phase and a command watchdog with throttle failsafe. It then drives the PWM generator's enable, period and active inputs so that new values are present exactly in the cycle the generator latches them.

---
 rtl/pwm_servo_ctrl.sv | 140 ++++++++++++++
 tb/tb_pwm_servo_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_servo_ctrl.sv
// Two-channel servo/ESC command sequencer: clamps and slew-limits host pulse widths,
// runs ESC arming and a throttle watchdog, and updates actives on frame boundaries.
module pwm_servo_ctrl #(
  parameter int CNT_WIDTH  = 24,
  parameter int PERIOD     = 2000000,
  parameter int NEUTRAL    = 150000,
  parameter int MIN_W      = 100000,
  parameter int MAX_W      = 200000,
  parameter int STEP       = 1000,
  parameter int ARM_FRAMES = 50,
  parameter int WD_FRAMES  = 25
) (
  input  logic                 axi_clk,
  input  logic                 axi_rst,
  input  logic                 ctrl_en_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_ch_i,
  input  logic [CNT_WIDTH-1:0] cmd_width_i,
  output logic                 pwm_enable_o,
  output logic [CNT_WIDTH-1:0] pwm_period_o,
  output logic [CNT_WIDTH-1:0] pwm_active_0_o,
  output logic [CNT_WIDTH-1:0] pwm_active_1_o,
  output logic                 frame_o,
  output logic [1:0]           state_o,
  output logic                 failsafe_o
);

  localparam int ARM_W = $clog2(ARM_FRAMES + 1);
  localparam int WD_W  = $clog2(WD_FRAMES + 1);
  localparam logic [CNT_WIDTH-1:0] PERIOD_C  = CNT_WIDTH'(PERIOD);
  localparam logic [CNT_WIDTH-1:0] NEUTRAL_C = CNT_WIDTH'(NEUTRAL);
  localparam logic [CNT_WIDTH-1:0] MIN_C     = CNT_WIDTH'(MIN_W);
  localparam logic [CNT_WIDTH-1:0] MAX_C     = CNT_WIDTH'(MAX_W);
  localparam logic [CNT_WIDTH:0]   STEP_C    = (CNT_WIDTH+1)'(STEP);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, FAILSAFE = 2'd3} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] frame_cnt;
  logic [CNT_WIDTH-1:0] tgt0, tgt1;
  logic [ARM_W-1:0]     arm_cnt;
  logic [WD_W-1:0]      wd_cnt;
  logic                 accept, wd_expire, slew_en;

  function automatic logic [CNT_WIDTH-1:0] clamp(input logic [CNT_WIDTH-1:0] w);
    if (w < MIN_C)      return MIN_C;
    else if (w > MAX_C) return MAX_C;
    else                return w;
  endfunction

  // One-step move toward tgt; extra bit keeps cur+STEP and tgt+STEP from wrapping.
  function automatic logic [CNT_WIDTH-1:0] slew(input logic [CNT_WIDTH-1:0] cur,
                                                input logic [CNT_WIDTH-1:0] tgt);
    logic [CNT_WIDTH:0] up, tgt_up;
    up     = {1'b0, cur} + STEP_C;
    tgt_up = {1'b0, tgt} + STEP_C;
    if (cur < tgt) return (up < {1'b0, tgt}) ? up[CNT_WIDTH-1:0] : tgt;
    else           return (tgt_up < {1'b0, cur}) ? (cur - STEP_C[CNT_WIDTH-1:0]) : tgt;
  endfunction

  assign pwm_enable_o = (state != IDLE);
  assign pwm_period_o = PERIOD_C;
  assign state_o      = state;
  assign frame_o      = pwm_enable_o && (frame_cnt == PERIOD_C - 1'b1);
  assign accept       = cmd_valid_i && cmd_ready_o;
  assign slew_en      = frame_o && (state == RUN || state == FAILSAFE);
  assign wd_expire    = (state == RUN) && frame_o && !accept &&
                        (wd_cnt == WD_W'(WD_FRAMES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (ctrl_en_i) state_nxt = ARM;
      ARM:      if (frame_o && arm_cnt == ARM_W'(ARM_FRAMES - 1)) state_nxt = RUN;
      RUN:      if (wd_expire) state_nxt = FAILSAFE;
      FAILSAFE: if (accept) state_nxt = RUN;
      default:  state_nxt = IDLE;
    endcase
    if (!ctrl_en_i) state_nxt = IDLE;
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state          <= IDLE;
      cmd_ready_o    <= 1'b0;
      failsafe_o     <= 1'b0;
      frame_cnt      <= '0;
      arm_cnt        <= '0;
      wd_cnt         <= '0;
      tgt0           <= NEUTRAL_C;
      tgt1           <= NEUTRAL_C;
      pwm_active_0_o <= NEUTRAL_C;
      pwm_active_1_o <= NEUTRAL_C;
    end else begin
      state       <= state_nxt;
      cmd_ready_o <= (state_nxt == RUN) || (state_nxt == FAILSAFE);
      failsafe_o  <= (state_nxt == FAILSAFE);

      // Counter sits at 0 in its first enabled cycle to track the generator.
      if (!pwm_enable_o || state_nxt == IDLE) frame_cnt <= '0;
      else if (frame_o)                       frame_cnt <= '0;
      else                                    frame_cnt <= frame_cnt + 1'b1;

      if (state_nxt == IDLE) begin
        arm_cnt        <= '0;
        wd_cnt         <= '0;
        tgt0           <= NEUTRAL_C;
        tgt1           <= NEUTRAL_C;
        pwm_active_0_o <= NEUTRAL_C;
        pwm_active_1_o <= NEUTRAL_C;
      end else begin
        if (state == ARM && frame_o) arm_cnt <= arm_cnt + 1'b1;

        if (accept)                     wd_cnt <= '0;
        else if (state == RUN && frame_o) wd_cnt <= wd_cnt + 1'b1;

        if (wd_expire) begin
          tgt0 <= NEUTRAL_C;
          tgt1 <= NEUTRAL_C;
        end else if (accept) begin
          if (cmd_ch_i) tgt1 <= clamp(cmd_width_i);
          else          tgt0 <= clamp(cmd_width_i);
        end

        // Throttle snaps to neutral on expiry; steering keeps slewing.
        if (slew_en) begin
          if (wd_expire) begin
            pwm_active_0_o <= slew(pwm_active_0_o, NEUTRAL_C);
            pwm_active_1_o <= NEUTRAL_C;
          end else begin
            pwm_active_0_o <= slew(pwm_active_0_o, tgt0);
            pwm_active_1_o <= slew(pwm_active_1_o, tgt1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_servo_ctrl.sv
// Directed bench for pwm_servo_ctrl using small frame/arm/watchdog parameters.
module tb_pwm_servo_ctrl;
  localparam int CW = 24;
  localparam int P  = 100;

  logic          clk = 1'b0;
  logic          rst, en, valid, ready, ch;
  logic [CW-1:0] width;
  logic          enable, frame, fs;
  logic [CW-1:0] period, a0, a1;
  logic [1:0]    state;

  int n_cmp = 0;
  int n_err = 0;

  pwm_servo_ctrl #(
    .CNT_WIDTH(CW), .PERIOD(P), .NEUTRAL(15), .MIN_W(10), .MAX_W(20),
    .STEP(2), .ARM_FRAMES(2), .WD_FRAMES(3)
  ) dut (
    .axi_clk(clk), .axi_rst(rst), .ctrl_en_i(en),
    .cmd_valid_i(valid), .cmd_ready_o(ready), .cmd_ch_i(ch), .cmd_width_i(width),
    .pwm_enable_o(enable), .pwm_period_o(period),
    .pwm_active_0_o(a0), .pwm_active_1_o(a1),
    .frame_o(frame), .state_o(state), .failsafe_o(fs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stops inside the frame_o cycle (before its ending edge).
  task automatic wait_frame_cycle(output int n);
    n = 0;
    while (!frame && n < P + 5) begin
      tick();
      n++;
    end
    if (!frame) check("frame_timeout", 32'(frame), 1);
  endtask

  task automatic next_frame();
    int n;
    wait_frame_cycle(n);
    tick();
  endtask

  task automatic send(input logic c, input logic [CW-1:0] w);
    int n;
    valid = 1'b1; ch = c; width = w;
    n = 0;
    while (!ready && n < 10) begin
      tick();
      n++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 1);
    tick();
    valid = 1'b0;
  endtask

  initial begin
    int n;
    int e0[3] = '{17, 19, 20};
    int e1[3] = '{13, 11, 10};
    rst = 1'b1; en = 1'b0; valid = 1'b0; ch = 1'b0; width = '0;
    tick(); tick();
    check("rst_enable", 32'(enable), 0);
    check("rst_period", period, 100);
    check("rst_a0", a0, 15);
    check("rst_a1", a1, 15);
    check("rst_frame", 32'(frame), 0);
    check("rst_state", 32'(state), 0);
    check("rst_fs", 32'(fs), 0);
    check("rst_ready", 32'(ready), 0);
    rst = 1'b0;
    tick();

    // Arming
    en = 1'b1;
    tick();
    check("arm_enable", 32'(enable), 1);
    check("arm_state", 32'(state), 1);
    wait_frame_cycle(n);
    check("arm_f1_delay", n, 99);
    check("arm_f1_a0", a0, 15);
    tick();
    check("arm_after_f1", 32'(state), 1);
    wait_frame_cycle(n);
    check("arm_f2_delay", n, 99);
    tick();
    check("run_state", 32'(state), 2);
    check("run_ready", 32'(ready), 1);
    check("run_a0", a0, 15);
    check("run_a1", a1, 15);

    // Slew, with ch1 low clamp
    send(1'b0, 24'd20);
    send(1'b1, 24'd5);
    for (int i = 0; i < 3; i++) begin
      next_frame();
      check("slew_a0", a0, e0[i]);
      check("slew_a1", a1, e1[i]);
      send(1'b0, 24'd20);
    end

    // High clamp: unclamped target would step a0 to 22
    send(1'b0, 24'hFFFFFF);
    next_frame();
    check("clamp_hi_a0", a0, 20);
    check("clamp_lo_a1", a1, 10);

    // Two ch0 commands in one frame: last (18) wins
    send(1'b0, 24'd12);
    send(1'b0, 24'd18);
    next_frame();
    check("last_wins_f1", a0, 18);
    send(1'b1, 24'd10);
    next_frame();
    check("last_wins_f2", a0, 18);

    // Ramp both to 20
    send(1'b0, 24'd20);
    send(1'b1, 24'd20);
    for (int i = 0; i < 5; i++) begin
      next_frame();
      check("ramp_a1", a1, 32'(12 + 2 * i));
      check("ramp_a0", a0, 20);
      send(1'b0, 24'd20);
    end

    // Watchdog expiry
    next_frame();
    check("wd_f1_state", 32'(state), 2);
    next_frame();
    check("wd_f2_state", 32'(state), 2);
    next_frame();
    check("wd_fs_state", 32'(state), 3);
    check("wd_fs_flag", 32'(fs), 1);
    check("wd_fs_a1", a1, 15);
    check("wd_fs_a0", a0, 18);
    check("wd_fs_ready", 32'(ready), 1);
    next_frame();
    check("fs_a0_2", a0, 16);
    check("fs_state_hold", 32'(state), 3);
    next_frame();
    check("fs_a0_3", a0, 15);
    send(1'b0, 24'd15);
    check("fs_exit_state", 32'(state), 2);
    check("fs_exit_flag", 32'(fs), 0);

    // Accept on the expiry frame_o cycle keeps RUN
    next_frame();
    next_frame();
    check("sim_pre_state", 32'(state), 2);
    wait_frame_cycle(n);
    valid = 1'b1; ch = 1'b1; width = 24'd15;
    tick();
    valid = 1'b0;
    check("sim_state", 32'(state), 2);
    check("sim_fs", 32'(fs), 0);
    next_frame();
    next_frame();
    check("sim_wd_cleared", 32'(state), 2);
    next_frame();
    check("sim_wd_expire", 32'(state), 3);
    send(1'b1, 24'd15);
    check("sim_resume", 32'(state), 2);

    // Abort mid-frame
    send(1'b0, 24'd20);
    next_frame();
    check("abort_pre_a0", a0, 17);
    repeat (10) tick();
    en = 1'b0;
    tick();
    check("abort_state", 32'(state), 0);
    check("abort_enable", 32'(enable), 0);
    check("abort_a0", a0, 15);
    check("abort_a1", a1, 15);
    check("abort_ready", 32'(ready), 0);
    check("abort_fs", 32'(fs), 0);
    repeat (5) tick();
    check("idle_frame", 32'(frame), 0);
    en = 1'b1;
    tick();
    check("rearm_state", 32'(state), 1);
    check("rearm_enable", 32'(enable), 1);
    wait_frame_cycle(n);
    check("rearm_f1_delay", n, 99);
    tick();
    check("rearm_after_f1", 32'(state), 1);
    wait_frame_cycle(n);
    tick();
    check("rearm_run", 32'(state), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
